sports_scorer_top: RTL and testbench

Two-digit sports score keeper driving a multiplexed 7-segment display. Key A toggles add/subtract mode. Key B changes the score by 1. Key C changes the score by 2. The score saturates in the range 00..99 and is shown on two time-multiplexed common-cathode digits. This is a top-level board block fed by already-debounced, clock-synchronous push-button levels.

---
 rtl/sports_scorer_pkg.sv | 25 ++
 rtl/sports_scorer_top_seg7_decoder.sv | 26 ++
 rtl/sports_scorer_top.sv | 82 ++++++++
 tb/tb_sports_scorer_top.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sports_scorer_pkg.sv
// Shared types and constants for the two-digit sports score keeper.
package sports_scorer_pkg;

  typedef enum logic {MODE_ADD, MODE_SUB} mode_t;

  // Segment patterns ordered {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

  localparam int unsigned STEP_B = 1;
  localparam int unsigned STEP_C = 2;

endpackage

// File: rtl/sports_scorer_top_seg7_decoder.sv
// Combinational BCD digit to 7-segment pattern; non-BCD codes blank the digit.
module seg7_decoder
  import sports_scorer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sports_scorer_top.sv
// Two-digit saturating score keeper with add/subtract mode and a
// time-multiplexed common-cathode 7-segment display.
module sports_scorer_top
  import sports_scorer_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_key_A,
  input  logic       I_key_B,
  input  logic       I_key_C,
  output logic [6:0] o_led,
  output logic [1:0] o_dx
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          key_a_q, key_b_q, key_c_q;
  logic          a_pulse, b_pulse, c_pulse;
  logic [1:0]    step;
  logic [7:0]    sum;
  logic [6:0]    score, score_next;
  mode_t         mode;
  logic [CW-1:0] scan_cnt;
  logic          scan_tc;
  logic [1:0]    dx_next;
  logic [3:0]    digit;
  logic [6:0]    seg;

  assign a_pulse = I_key_A & ~key_a_q;
  assign b_pulse = I_key_B & ~key_b_q;
  assign c_pulse = I_key_C & ~key_c_q;

  assign step = (b_pulse ? 2'(STEP_B) : '0) + (c_pulse ? 2'(STEP_C) : '0);
  assign sum  = {1'b0, score} + {6'b0, step};

  // Saturating update uses the mode in effect before any same-cycle toggle
  always_comb begin
    score_next = score;
    if (mode == MODE_ADD)
      score_next = (sum > 8'(SCORE_MAX)) ? 7'(SCORE_MAX) : sum[6:0];
    else
      score_next = ({5'b0, step} > score) ? '0 : score - {5'b0, step};
  end

  assign scan_tc = (scan_cnt == CW'(SCAN_DIV - 1));
  assign dx_next = scan_tc ? {o_dx[0], o_dx[1]} : o_dx;

  // Decode the digit that will be selected next so o_led and o_dx stay aligned
  assign digit = (dx_next == DIG_TENS) ? 4'(score / 7'd10) : 4'(score % 7'd10);

  seg7_decoder u_seg7_decoder (
    .bcd (digit),
    .seg (seg)
  );

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      key_a_q  <= 1'b0;
      key_b_q  <= 1'b0;
      key_c_q  <= 1'b0;
      score    <= '0;
      mode     <= MODE_ADD;
      scan_cnt <= '0;
      o_dx     <= DIG_UNITS;
      o_led    <= SEG_0;
    end else begin
      key_a_q  <= I_key_A;
      key_b_q  <= I_key_B;
      key_c_q  <= I_key_C;
      score    <= score_next;
      if (a_pulse)
        mode <= (mode == MODE_ADD) ? MODE_SUB : MODE_ADD;
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      o_dx     <= dx_next;
      o_led    <= seg;
    end
  end

endmodule

// File: tb/tb_sports_scorer_top.sv
// Directed and randomized checks of the score keeper against an arithmetic reference model.
module tb_sports_scorer_top;

  localparam int SD = 4;
  localparam int SMAX = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_a = 1'b0, key_b = 1'b0, key_c = 1'b0;
  logic [6:0] led;
  logic [1:0] dx;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  // reference model state
  int         m_score = 0;
  bit         m_sub = 0;
  bit         pa = 0, pb = 0, pc = 0;
  int         m_cnt = 0;
  logic [1:0] m_dx = 2'b01;
  logic [6:0] m_led = 7'b0111111;

  sports_scorer_top #(.SCAN_DIV(SD), .SCORE_MAX(SMAX)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .I_key_A (key_a),
    .I_key_B (key_b),
    .I_key_C (key_c),
    .o_led   (led),
    .o_dx    (dx)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic rn, input logic a, input logic b, input logic c);
    int old, step;
    rst_n = rn; key_a = a; key_b = b; key_c = c;
    @(posedge clk);
    if (!rn) begin
      m_score = 0; m_sub = 0; pa = 0; pb = 0; pc = 0;
      m_cnt = 0; m_dx = 2'b01; m_led = seg_tab[0];
    end else begin
      old  = m_score;
      step = 0;
      if (b && !pb) step += 1;
      if (c && !pc) step += 2;
      if (!m_sub) m_score = (old + step > SMAX) ? SMAX : old + step;
      else        m_score = (old - step < 0) ? 0 : old - step;
      if (a && !pa) m_sub = !m_sub;
      pa = a; pb = b; pc = c;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_dx  = (m_dx == 2'b01) ? 2'b10 : 2'b01;
      end else begin
        m_cnt++;
      end
      m_led = (m_dx == 2'b10) ? seg_tab[old / 10] : seg_tab[old % 10];
    end
    #1;
    checks++;
    assert (dx === m_dx) else begin
      errors++;
      $error("FAIL dx observed=%b expected=%b t=%0t", dx, m_dx, $time);
    end
    checks++;
    assert (led === m_led) else begin
      errors++;
      $error("FAIL led observed=%b expected=%b t=%0t", led, m_led, $time);
    end
  endtask

  task automatic press(input logic a, input logic b, input logic c, input int hold);
    for (int i = 0; i < hold; i++) tick(1'b1, a, b, c);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Scan idle for two full periods and compare what each digit position showed
  task automatic check_digits(input string tag, input logic [6:0] exp_tens, input logic [6:0] exp_units);
    logic [6:0] seen_t, seen_u;
    bit got_t, got_u;
    got_t = 0; got_u = 0; seen_t = 'x; seen_u = 'x;
    for (int i = 0; i < 2 * SD + 2; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (dx === 2'b10) begin seen_t = led; got_t = 1; end
      if (dx === 2'b01) begin seen_u = led; got_u = 1; end
    end
    checks++;
    assert (got_t && got_u && seen_t === exp_tens) else begin
      errors++;
      $error("FAIL %s_tens observed=%b expected=%b", tag, seen_t, exp_tens);
    end
    checks++;
    assert (seen_u === exp_units) else begin
      errors++;
      $error("FAIL %s_units observed=%b expected=%b", tag, seen_u, exp_units);
    end
  endtask

  initial begin
    // 1: reset and first scan swap
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (dx === 2'b01 && led === 7'b0111111) else begin
      errors++;
      $error("FAIL reset observed=%b/%b expected=01/0111111", dx, led);
    end
    for (int i = 0; i < SD; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (dx === 2'b10 && led === 7'b0111111) else begin
      errors++;
      $error("FAIL first_swap observed=%b/%b expected=10/0111111", dx, led);
    end

    // 2: long hold counts once, then two short presses -> 03
    press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 1'b0, 2);
    check_digits("add3", 7'b0111111, 7'b1001111);

    // 3: switch to SUB, 3 -> 1
    press(1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 1'b0, 2);
    check_digits("sub1", 7'b0111111, 7'b0000110);

    // 4: subtract 2 from 1 saturates at 00
    press(1'b0, 1'b0, 1'b1, 2);
    check_digits("floor", 7'b0111111, 7'b0111111);

    // 5: back to ADD, climb to 98, then saturate at 99
    press(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 49; i++) press(1'b0, 1'b0, 1'b1, 1);
    check_digits("n98", 7'b1101111, 7'b1111111);
    press(1'b0, 1'b0, 1'b1, 1);
    check_digits("ceil", 7'b1101111, 7'b1101111);
    press(1'b0, 1'b1, 1'b0, 1);
    check_digits("ceil_b", 7'b1101111, 7'b1101111);

    // 6: reset, go to 10, B+C -> 13, A+B -> 14 and SUB, then B -> 13
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b0, 1'b1, 1);
    press(1'b0, 1'b1, 1'b1, 1);
    check_digits("bc", 7'b0000110, 7'b1001111);
    press(1'b1, 1'b1, 1'b0, 1);
    check_digits("ab", 7'b0000110, 7'b1100110);
    press(1'b0, 1'b1, 1'b0, 1);
    check_digits("sub_after", 7'b0000110, 7'b1001111);

    // mid-scan reset for a single edge
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (dx === 2'b01 && led === 7'b0111111) else begin
      errors++;
      $error("FAIL midreset observed=%b/%b expected=01/0111111", dx, led);
    end

    // randomized keys with occasional reset
    for (int i = 0; i < 600; i++)
      tick(logic'($urandom_range(0, 63) != 0),
           logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 2) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
